uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 74 +++++++
 rtl/uart_tx_cfg.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode codes.
// Used by the transmitter and by the receiver when it joins this slice.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Code 2'b11 is also "none", so test for the two active codes explicitly.
   function automatic logic par_active(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with parametrised width and depth (DEPTH a power of two).
// The head word is presented combinationally on rdata_o. Pushes while full and
// pops while empty are ignored. count_nxt_o exposes next-cycle occupancy so a
// parent can register a ready flag that tracks the level without lag.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [$clog2(DEPTH):0]   count_nxt_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign do_push     = push_i & ~full_o;
   assign do_pop      = pop_i & ~empty_o;
   assign rdata_o     = mem_q[rptr_q];
   assign count_o     = count_q;
   assign count_nxt_o = count_d;

   // Occupancy next state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^n.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with TX FIFO and per-frame latched configuration.
// Optional parity (parity_mode port and PARITY state) is built only when
// UART_TX_PARITY_EN is defined; otherwise frames carry no parity bit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line high, waiting for a FIFO word
// ST_START  | start bit (low) for one bit period
// ST_DATA   | DATA_W data bits, LSB first
// ST_PARITY | parity bit (parity builds only, skipped when mode is none)
// ST_STOP   | line high for STOP_BITS bit periods, then IDLE or next START
//
// tx and busy are registered from the current state, so they trail the state
// register by one clk. Every phase keeps its full length; the only visible
// effect is the 2-clk latency from accepting edge to the falling start edge.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_W-1:0]             tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [DIV_W-1:0]              baud_div,
`ifdef UART_TX_PARITY_EN
   input  logic [1:0]                    parity_mode,
`endif
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = 4;

   uart_state_e       state_q;
   logic [DIV_W-1:0]  cnt_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_load;
   logic [BIT_W-1:0]  bit_q;
   logic              stop_q;
   logic [DATA_W-1:0] sh_q;
   logic              tx_q;
   logic              busy_q;
   logic              tx_ready_q;
`ifdef UART_TX_PARITY_EN
   logic              par_en_q;
   logic              par_bit_q;
`endif

   logic              push;
   logic              pop;
   logic              bit_end;
   logic              last_stop;
   logic              last_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] head;
   logic [LVL_W-1:0]  level;
   logic [LVL_W-1:0]  level_nxt;

   assign push = tx_valid & tx_ready_q & ~fifo_full;

   uart_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .wdata_i     (tx_data),
      .pop_i       (pop),
      .rdata_o     (head),
      .count_o     (level),
      .count_nxt_o (level_nxt),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Bit timer reloads with max(baud_div,1)-1 and counts down to zero.
   assign div_load  = (baud_div == '0) ? '0 : (baud_div - DIV_W'(1));
   assign bit_end   = (cnt_q == '0);
   assign last_stop = (stop_q == 1'(STOP_BITS - 1));
   assign last_data = (bit_q == BIT_W'(DATA_W - 1));

   // Pop from IDLE, or at the end of the final stop bit for back-to-back frames.
   assign pop = ~fifo_empty &
                ((state_q == ST_IDLE) |
                 ((state_q == ST_STOP) & bit_end & last_stop));

   // Frame sequencer with registered line and busy outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         bit_q     <= '0;
         stop_q    <= 1'b0;
         sh_q      <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         busy_q <= (state_q != ST_IDLE);
         case (state_q)
            ST_START:  tx_q <= 1'b0;
            ST_DATA:   tx_q <= sh_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_q <= par_bit_q;
`endif
            default:   tx_q <= 1'b1;
         endcase

         if (pop) begin
            // Divisor and parity mode are sampled here and held for the frame.
            state_q   <= ST_START;
            cnt_q     <= div_load;
            div_q     <= div_load;
            sh_q      <= head;
            bit_q     <= '0;
            stop_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_active(parity_mode);
            par_bit_q <= (^head) ^ (parity_mode == PAR_ODD);
`endif
         end else if (state_q != ST_IDLE) begin
            if (!bit_end) begin
               cnt_q <= cnt_q - DIV_W'(1);
            end else begin
               cnt_q <= div_q;
               case (state_q)
                  ST_START: begin
                     state_q <= ST_DATA;
                     bit_q   <= '0;
                  end
                  ST_DATA: begin
                     sh_q  <= sh_q >> 1;
                     bit_q <= bit_q + BIT_W'(1);
                     if (last_data) begin
                        stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_q <= par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_q <= ST_STOP;
`endif
                     end
                  end
`ifdef UART_TX_PARITY_EN
                  ST_PARITY: begin
                     stop_q  <= 1'b0;
                     state_q <= ST_STOP;
                  end
`endif
                  ST_STOP: begin
                     if (last_stop) begin
                        state_q <= ST_IDLE;
                     end else begin
                        stop_q <= 1'b1;
                     end
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end
      end
   end

   // Ready tracks next-cycle occupancy so it is registered yet never stale.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_ready_q <= 1'b0;
      end else begin
         tx_ready_q <= (level_nxt < LVL_W'(FIFO_DEPTH));
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign tx_ready   = tx_ready_q;
   assign fifo_level = level;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg. Two instances: dut_a (1 stop bit) and
// dut_b (2 stop bits). Parity frames are exercised when UART_TX_PARITY_EN
// is defined, otherwise the no-parity frame shape is checked.
module tb_uart_tx_cfg;

   logic        clk;
   logic        a_rst, a_valid, a_ready, a_tx, a_busy;
   logic [7:0]  a_data;
   logic [15:0] a_div;
   logic [2:0]  a_level;
   logic        b_rst, b_valid, b_ready, b_tx, b_busy;
   logic [7:0]  b_data;
   logic [15:0] b_div;
   logic [2:0]  b_level;
`ifdef UART_TX_PARITY_EN
   logic [1:0]  a_par;
   logic [1:0]  b_par;
`endif

   int          n_checks;
   int          n_fail;
   int          qbad;
   logic [7:0]  w6 [0:5];

   uart_tx_cfg #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1), .DIV_W(16)) dut_a (
      .clk         (clk),
      .rst         (a_rst),
      .tx_data     (a_data),
      .tx_valid    (a_valid),
      .tx_ready    (a_ready),
      .baud_div    (a_div),
`ifdef UART_TX_PARITY_EN
      .parity_mode (a_par),
`endif
      .tx          (a_tx),
      .busy        (a_busy),
      .fifo_level  (a_level)
   );

   uart_tx_cfg #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(2), .DIV_W(16)) dut_b (
      .clk         (clk),
      .rst         (b_rst),
      .tx_data     (b_data),
      .tx_valid    (b_valid),
      .tx_ready    (b_ready),
      .baud_div    (b_div),
`ifdef UART_TX_PARITY_EN
      .parity_mode (b_par),
`endif
      .tx          (b_tx),
      .busy        (b_busy),
      .fifo_level  (b_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call on the first cycle where tx is low; returns on the last stop cycle.
   task automatic check_frame(input string tag, input bit use_b, input logic [7:0] word,
                              input int div, input bit has_par, input logic parbit,
                              input int nstop);
      logic exp_bits[$];
      int   per;
      int   bad;
      logic obs_tx;
      logic obs_busy;
      per = (div == 0) ? 1 : div;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(word[i]);
      if (has_par) exp_bits.push_back(parbit);
      for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
      bad = 0;
      for (int b = 0; b < exp_bits.size(); b++) begin
         for (int c = 0; c < per; c++) begin
            if (b != 0 || c != 0) tick();
            obs_tx   = use_b ? b_tx : a_tx;
            obs_busy = use_b ? b_busy : a_busy;
            if (obs_tx !== exp_bits[b] || obs_busy !== 1'b1) bad++;
         end
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      a_rst = 1'b1; a_valid = 1'b0; a_data = 8'h00; a_div = 16'd4;
      b_rst = 1'b1; b_valid = 1'b0; b_data = 8'h00; b_div = 16'd0;
`ifdef UART_TX_PARITY_EN
      a_par = 2'b00;
      b_par = 2'b00;
`endif
      w6[0] = 8'h11; w6[1] = 8'h22; w6[2] = 8'h33;
      w6[3] = 8'h44; w6[4] = 8'h55; w6[5] = 8'h66;

      // Reset values, asynchronously, before any clock edge
      #1;
      a_rst = 1'b0;
      b_rst = 1'b0;
      #2;
      chk("rst_tx", a_tx, 1);
      chk("rst_busy", a_busy, 0);
      chk("rst_ready", a_ready, 0);
      chk("rst_level", a_level, 0);
      tick();
      a_rst = 1'b1;
      b_rst = 1'b1;
      chk("ready_before_edge", a_ready, 0);
      tick();
      chk("ready_first_edge", a_ready, 1);

      // 0x55 at baud_div 4: 2-clk latency then 40-clk frame
      a_data = 8'h55; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("push_level", a_level, 1);
      chk("lat_1clk_tx", a_tx, 1);
      tick();
      chk("lat_pop_level", a_level, 0);
      chk("lat_1clk_tx_still_high", a_tx, 1);
      tick();
      chk("lat_2clk_tx", a_tx, 0);
      check_frame("frame_55", 1'b0, 8'h55, 4, 1'b0, 1'b0, 1);
      tick();
      chk("frame_55_busy_end", a_busy, 0);
      chk("frame_55_tx_idle", a_tx, 1);

`ifdef UART_TX_PARITY_EN
      // 0x07: even parity bit 1, odd parity bit 0
      a_div = 16'd2; a_par = 2'b01;
      a_data = 8'h07; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      chk("par_even_start", a_tx, 0);
      check_frame("par_even_07", 1'b0, 8'h07, 2, 1'b1, 1'b1, 1);
      tick();
      chk("par_even_busy_end", a_busy, 0);
      a_par = 2'b10;
      a_data = 8'h07; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      chk("par_odd_start", a_tx, 0);
      check_frame("par_odd_07", 1'b0, 8'h07, 2, 1'b1, 1'b0, 1);
      tick();
      chk("par_odd_busy_end", a_busy, 0);
      a_par = 2'b00;
`else
      // No parity build: 0x07 is a 10-bit frame
      a_div = 16'd2;
      a_data = 8'h07; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      chk("nopar_start", a_tx, 0);
      check_frame("nopar_07", 1'b0, 8'h07, 2, 1'b0, 1'b0, 1);
      tick();
      chk("nopar_busy_end", a_busy, 0);
`endif

      // baud_div 4 -> 8 during frame 1; push/pop in the same cycle
      a_div = 16'd4;
      a_data = 8'hA3; a_valid = 1'b1;
      tick();
      a_data = 8'h3C;
      chk("b2b_level_1", a_level, 1);
      tick();
      a_valid = 1'b0;
      chk("b2b_level_pushpop", a_level, 1);
      tick();
      chk("b2b_start", a_tx, 0);
      a_div = 16'd8;
      check_frame("div4_frame_A3", 1'b0, 8'hA3, 4, 1'b0, 1'b0, 1);
      tick();
      check_frame("div8_frame_3C", 1'b0, 8'h3C, 8, 1'b0, 1'b0, 1);
      tick();
      chk("div_chg_busy_end", a_busy, 0);

      // baud_div 10, six words with tx_valid held high
      a_div = 16'd10;
      fork
         begin : drv
            int   k;
            int   cyc;
            logic rdy;
            k = 0;
            cyc = 0;
            while (k < 6 && cyc < 400) begin
               a_data  = w6[k];
               a_valid = 1'b1;
               rdy     = a_ready;
               tick();
               cyc++;
               if (rdy) k++;
               if (cyc == 10) begin
                  chk("burst_accepted_5", k, 5);
                  chk("burst_ready_low", a_ready, 0);
                  chk("burst_level_full", a_level, 4);
               end
               if (cyc == 90) chk("burst_ready_low_late", a_ready, 0);
            end
            a_valid = 1'b0;
            chk("burst_all_accepted", k, 6);
         end
         begin : mon
            int waited;
            waited = 0;
            while (a_tx !== 1'b0 && waited < 50) begin
               tick();
               waited++;
            end
            chk("burst_start_seen", a_tx, 0);
            for (int j = 0; j < 6; j++) begin
               if (j > 0) tick();
               check_frame("burst_frame", 1'b0, w6[j], 10, 1'b0, 1'b0, 1);
            end
            tick();
            chk("burst_busy_end", a_busy, 0);
         end
      join

      // Reset mid data bit 3 with two words queued
      a_div = 16'd4;
      a_data = 8'hF0; a_valid = 1'b1;
      tick();
      a_data = 8'h81;
      tick();
      a_data = 8'h42;
      tick();
      a_valid = 1'b0;
      chk("rstmid_start", a_tx, 0);
      chk("rstmid_level_2", a_level, 2);
      repeat (17) tick();
      chk("rstmid_bit3_low", a_tx, 0);
      #1;
      a_rst = 1'b0;
      #1;
      chk("rstmid_tx", a_tx, 1);
      chk("rstmid_level", a_level, 0);
      chk("rstmid_busy", a_busy, 0);
      chk("rstmid_ready", a_ready, 0);
      tick();
      a_rst = 1'b1;
      qbad = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_level !== 3'd0) qbad++;
      end
      chk("rstmid_quiet", qbad, 0);
      a_data = 8'h0F; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      chk("post_rst_start", a_tx, 0);
      check_frame("post_rst_0F", 1'b0, 8'h0F, 4, 1'b0, 1'b0, 1);
      tick();
      chk("post_rst_busy_end", a_busy, 0);

      // dut_b: baud_div 0 and two stop bits, 0xFF -> 11-clk frame
      b_data = 8'hFF; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      chk("div0_start", b_tx, 0);
      check_frame("div0_ff_2stop", 1'b1, 8'hFF, 0, 1'b0, 1'b0, 2);
      tick();
      chk("div0_busy_end", b_busy, 0);
      chk("div0_tx_idle", b_tx, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
